// File: rtl/lfsr_backoff_sched_pkg.sv
// Shared types and widths for the LFSR backoff scheduler.
package lfsr_backoff_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_COUNT,
      ST_DONE
   } state_t;

   localparam int unsigned LFSR_W  = 14;
   localparam int unsigned CNT_W   = 15;
   localparam int unsigned WIN_MAX = 14;

   // Exponents above WIN_MAX clamp; exponent 0 yields an all-zero mask.
   function automatic logic [CNT_W-1:0] win_mask(input logic [3:0] win_exp);
      logic [3:0] win;
      win = (win_exp > 4'(WIN_MAX)) ? 4'(WIN_MAX) : win_exp;
      return (CNT_W'(1) << win) - CNT_W'(1);
   endfunction

endpackage

// File: rtl/lfsr_backoff_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module lfsr_backoff_sched_rr_arbiter #(
   parameter int unsigned P_NUM_REQ = 4,
   parameter int unsigned P_PTR_W   = 2
) (
   input  logic [P_NUM_REQ-1:0] req,
   input  logic [P_PTR_W-1:0]   ptr,
   output logic [P_NUM_REQ-1:0] grant,
   output logic                 any
);

   logic               found;
   logic [P_PTR_W-1:0] idx;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < P_NUM_REQ; i++) begin
         idx = P_PTR_W'((32'(ptr) + i) % P_NUM_REQ);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/lfsr_backoff_sched.sv
// Shares one LFSR stream among requesters: arbitrate, sample a windowed delay,
// count it down and report done (or abort if the owner withdraws).
module lfsr_backoff_sched
   import lfsr_backoff_sched_pkg::*;
#(
   parameter int unsigned P_NUM_REQ = 4,
   parameter int unsigned P_MIN_GAP = 8,
   parameter int unsigned P_LFSR_W  = LFSR_W
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [P_LFSR_W-1:0]  i_lfsr_value,
   input  logic [P_NUM_REQ-1:0] i_req,
   input  logic [3:0]           i_win_exp,
   output logic [P_NUM_REQ-1:0] o_grant,
   output logic [P_NUM_REQ-1:0] o_done,
   output logic                 o_abort,
   output logic                 o_busy,
   output logic [CNT_W-1:0]     o_delay_cnt
);

   localparam int unsigned PTR_W = (P_NUM_REQ > 1) ? $clog2(P_NUM_REQ) : 1;

   state_t               state_q, state_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d, owner_q, owner_d, win_idx, ptr_nxt;
   logic [P_NUM_REQ-1:0] arb_grant, grant_d, done_d;
   logic                 any_req, abort_d, busy_d;
   logic [CNT_W-1:0]     cnt_d, load_val;

   lfsr_backoff_sched_rr_arbiter #(
      .P_NUM_REQ (P_NUM_REQ),
      .P_PTR_W   (PTR_W)
   ) u_arb (
      .req   (i_req),
      .ptr   (ptr_q),
      .grant (arb_grant),
      .any   (any_req)
   );

   always_comb begin
      win_idx = '0;
      for (int unsigned i = 0; i < P_NUM_REQ; i++) begin
         if (arb_grant[i]) win_idx = PTR_W'(i);
      end
   end

   assign load_val = (CNT_W'(i_lfsr_value) & win_mask(i_win_exp)) + CNT_W'(P_MIN_GAP);
   assign ptr_nxt  = (owner_q == PTR_W'(P_NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

   // Outputs are computed from the next state so that they appear registered
   // in the same cycle the state register enters the corresponding state.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      cnt_d   = o_delay_cnt;
      grant_d = o_grant;
      done_d  = '0;
      abort_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               owner_d = win_idx;
               grant_d = arb_grant;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            cnt_d   = load_val;
            state_d = ST_COUNT;
         end
         ST_COUNT: begin
            if (!i_req[owner_q]) begin
               abort_d = 1'b1;
               grant_d = '0;
               cnt_d   = '0;
               ptr_d   = ptr_nxt;
               state_d = ST_IDLE;
            end else if (o_delay_cnt == '0) begin
               done_d  = o_grant;
               state_d = ST_DONE;
            end else begin
               cnt_d = o_delay_cnt - 1'b1;
            end
         end
         ST_DONE: begin
            grant_d = '0;
            ptr_d   = ptr_nxt;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         owner_q     <= '0;
         o_delay_cnt <= '0;
         o_grant     <= '0;
         o_done      <= '0;
         o_abort     <= 1'b0;
         o_busy      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         o_delay_cnt <= cnt_d;
         o_grant     <= grant_d;
         o_done      <= done_d;
         o_abort     <= abort_d;
         o_busy      <= busy_d;
      end
   end

endmodule

// File: tb/tb_lfsr_backoff_sched.sv
// Directed + randomized bench for lfsr_backoff_sched against an arithmetic reference model.
module tb_lfsr_backoff_sched;

   localparam int NREQ = 4;
   localparam int GAP  = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [13:0] lfsr;
   logic [3:0]  req;
   logic [3:0]  win;
   logic [3:0]  o_grant, o_done;
   logic        o_abort, o_busy;
   logic [14:0] o_delay_cnt;

   int n_cmp = 0;
   int n_err = 0;
   int ptr_m = 0;

   lfsr_backoff_sched #(
      .P_NUM_REQ (NREQ),
      .P_MIN_GAP (GAP),
      .P_LFSR_W  (14)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_lfsr_value (lfsr),
      .i_req        (req),
      .i_win_exp    (win),
      .o_grant      (o_grant),
      .o_done       (o_done),
      .o_abort      (o_abort),
      .o_busy       (o_busy),
      .o_delay_cnt  (o_delay_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance past one rising edge; the free-running LFSR and window keep changing.
   task automatic step();
      @(posedge clk);
      #1;
      lfsr = 14'($urandom);
      win  = 4'($urandom);
   endtask

   function automatic int model_delay(input int unsigned v, input int unsigned w);
      int unsigned e;
      e = (w > 14) ? 14 : w;
      return int'(v % (32'd1 << e)) + GAP;
   endfunction

   function automatic int rr_pick(input logic [3:0] r, input int p);
      logic [3:0] sh;
      for (int k = 0; k < NREQ; k++) begin
         sh = r >> ((p + k) % NREQ);
         if (sh[0]) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic do_txn(input int owner, input logic [13:0] v, input logic [3:0] w,
                         input logic [3:0] new_req);
      int d, bad;
      logic [3:0] oh;
      oh = 4'(1 << owner);
      step();
      chk("grant", 32'(o_grant), 32'(oh));
      chk("busy_on", 32'(o_busy), 1);
      chk("abort_idle", 32'(o_abort), 0);
      lfsr = v;
      win  = w;
      d    = model_delay(v, w);
      step();
      chk("load_cnt", 32'(o_delay_cnt), d);
      bad = 0;
      for (int k = 0; k < d; k++) begin
         step();
         if (o_done !== 4'd0 || o_grant !== oh || o_abort !== 1'b0 ||
             o_delay_cnt !== 15'(d - k - 1)) bad++;
      end
      chk("countdown", bad, 0);
      step();
      chk("done", 32'(o_done), 32'(oh));
      chk("grant_in_done", 32'(o_grant), 32'(oh));
      req = new_req;
      step();
      chk("done_pulse", 32'(o_done), 0);
      chk("busy_off", 32'(o_busy), 0);
      chk("grant_off", 32'(o_grant), 0);
      ptr_m = (owner + 1) % NREQ;
   endtask

   task automatic do_abort(input int owner, input logic [13:0] v, input logic [3:0] w,
                           input int at_cnt, input logic [3:0] new_req);
      int d, bad;
      logic [3:0] oh;
      oh = 4'(1 << owner);
      step();
      chk("ab_grant", 32'(o_grant), 32'(oh));
      lfsr = v;
      win  = w;
      d    = model_delay(v, w);
      step();
      chk("ab_load_cnt", 32'(o_delay_cnt), d);
      bad = 0;
      for (int k = 0; k < d - at_cnt; k++) begin
         step();
         if (o_done !== 4'd0 || o_abort !== 1'b0) bad++;
      end
      chk("ab_quiet", bad, 0);
      chk("ab_cnt_at_drop", 32'(o_delay_cnt), at_cnt);
      req = new_req;
      step();
      chk("abort", 32'(o_abort), 1);
      chk("abort_no_done", 32'(o_done), 0);
      chk("abort_grant", 32'(o_grant), 0);
      chk("abort_busy", 32'(o_busy), 0);
      ptr_m = (owner + 1) % NREQ;
   endtask

   initial begin
      int o, bad;
      logic [3:0] nxt, oh;

      rst = 1'b1; req = '0; lfsr = '0; win = '0;
      step();
      step();
      chk("rst_grant", 32'(o_grant), 0);
      chk("rst_done", 32'(o_done), 0);
      chk("rst_abort", 32'(o_abort), 0);
      chk("rst_busy", 32'(o_busy), 0);
      chk("rst_cnt", 32'(o_delay_cnt), 0);
      rst = 1'b0;

      // Reset while counting 20: operation vanishes, pointer returns to 0.
      req = 4'b0010;
      step();
      chk("mid_grant", 32'(o_grant), 32'h2);
      lfsr = 14'h1F; win = 4'd5;
      step();
      for (int k = 0; k < 19; k++) step();
      chk("mid_cnt", 32'(o_delay_cnt), 20);
      rst = 1'b1; req = '0;
      step();
      rst = 1'b0;
      chk("mid_busy", 32'(o_busy), 0);
      chk("mid_grant_off", 32'(o_grant), 0);
      chk("mid_cnt_clr", 32'(o_delay_cnt), 0);
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         if (o_done !== 4'd0 || o_abort !== 1'b0 || o_busy !== 1'b0) bad++;
         step();
      end
      chk("mid_silent", bad, 0);
      ptr_m = 0;

      // Fairness with all requesting; each drops after its done.
      req = 4'b1111;
      for (int k = 0; k < NREQ; k++)
         do_txn(k, 14'($urandom), 4'($urandom_range(0, 4)), req & ~4'(1 << k));
      req = 4'b1111;
      do_txn(0, 14'($urandom), 4'd2, 4'b0000);

      req = 4'b0010;
      do_txn(1, 14'h3A5, 4'd4, 4'b0000);
      req = 4'b0001;
      do_txn(0, 14'($urandom), 4'd0, 4'b0000);
      req = 4'b1000;
      do_txn(3, 14'h3FFF, 4'd15, 4'b0000);

      // Abort by requester 2 at count 6; requester 3 idle so 0 wins next.
      req = 4'b0010;
      do_txn(1, 14'($urandom), 4'd3, 4'b0000);
      req = 4'b0101;
      do_abort(2, 14'($urandom), 4'd4, 6, 4'b0001);
      do_txn(rr_pick(req, ptr_m), 14'($urandom), 4'd2, 4'b0000);

      req = 4'b0100;
      do_abort(2, 14'($urandom), 4'd3, 0, 4'b0000);

      for (int it = 0; it < 14; it++) begin
         if (req == 4'd0) req = 4'($urandom_range(1, 15));
         o   = rr_pick(req, ptr_m);
         oh  = 4'(1 << o);
         nxt = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) begin
            nxt = nxt & ~oh;
            do_abort(o, 14'($urandom), 4'($urandom_range(0, 5)), $urandom_range(0, 8), nxt);
         end else begin
            do_txn(o, 14'($urandom), 4'($urandom_range(0, 5)), nxt);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
